// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the alarm timekeeper: 24 h time struct, FSM states, range check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timekeeper_pkg;

  localparam logic [4:0] MAX_HOUR   = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  // Internal time is always 24 h; packed so it lines up with the 17-bit time buses.
  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } tk_time_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } tk_state_t;

  function automatic logic time_valid(input tk_time_t t);
    return (t.hour <= MAX_HOUR) && (t.min <= MAX_MINSEC) && (t.sec <= MAX_MINSEC);
  endfunction

endpackage

// File: rtl/alarm_timekeeper_if.sv
// Control, alarm-programming and display bundle of the alarm timekeeper.
// Latency: n/a (wiring only).
// Backpressure: none; every input is sampled each clk.
interface alarm_timekeeper_if #(
  parameter int NUM_ALARMS = 2
);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  tick;
  logic                  time_ow;
  logic [16:0]           time_in;
  logic [16:0]           initial_time;
  logic                  time_pause;
  logic                  hour_inc;
  logic                  hour_dec;
  logic                  min_inc;
  logic                  min_dec;
  logic                  alarm_wr;
  logic                  alarm_clr;
  logic [SEL_W-1:0]      alarm_sel;
  logic                  alarm_ack;
  logic [NUM_ALARMS-1:0] alarm_ring;
  logic [4:0]            hour_out;
  logic [5:0]            min_out;
  logic [5:0]            sec_out;
  logic                  pm;
  logic                  running;
  logic [23:0]           bcd_out;

  modport master (
    output tick, time_ow, time_in, initial_time, time_pause,
    output hour_inc, hour_dec, min_inc, min_dec,
    output alarm_wr, alarm_clr, alarm_sel, alarm_ack,
    input  alarm_ring, hour_out, min_out, sec_out, pm, running, bcd_out
  );

  modport slave (
    input  tick, time_ow, time_in, initial_time, time_pause,
    input  hour_inc, hour_dec, min_inc, min_dec,
    input  alarm_wr, alarm_clr, alarm_sel, alarm_ack,
    output alarm_ring, hour_out, min_out, sec_out, pm, running, bcd_out
  );

endinterface

// File: rtl/bin2bcd_2dig.sv
// Splits a 0..63 binary value into tens and ones BCD digits.
// Latency: combinational.
// Backpressure: none.
module bin2bcd_2dig (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  assign tens = 4'(bin / 6'd10);
  assign ones = 4'(bin % 6'd10);

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day keeper with RUN/PAUSE FSM, button editing, time overwrite and optional alarms (ALARM_TIMEKEEPER_ALARM_EN).
// Latency: time/alarm state registered; display, pm and BCD follow the registers combinationally.
// Backpressure: none; tick, button edges and writes are consumed in the clk they arrive.
module alarm_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int HOUR_12    = 0,
  parameter int NUM_ALARMS = 2
) (
  input logic               clk,
  input logic               time_reset_n,
  alarm_timekeeper_if.slave bus
);

  if (NUM_ALARMS < 1 || NUM_ALARMS > 4) begin : g_bad_num_alarms
    $error("NUM_ALARMS must be in 1..4");
  end

  tk_state_t  state_q, state_nxt;
  tk_time_t   time_q, time_nxt, tick_time, edit_time, ow_time, init_time;
  logic [4:0] btn_now, btn_q, btn_edge;
  logic       pause_edge, hr_inc_edge, hr_dec_edge, mn_inc_edge, mn_dec_edge;
  logic       running;
  logic       tick_adv;
  logic [4:0] disp_hour;
  logic       pm_flag;
  logic [7:0] bcd_hour, bcd_min, bcd_sec;

  assign ow_time   = bus.time_in;
  assign init_time = bus.initial_time;

  assign btn_now  = {bus.time_pause, bus.hour_inc, bus.hour_dec, bus.min_inc, bus.min_dec};
  assign btn_edge = btn_now & ~btn_q;
  assign {pause_edge, hr_inc_edge, hr_dec_edge, mn_inc_edge, mn_dec_edge} = btn_edge;

  // One registered sample per button so a held button yields a single rising edge.
  always_ff @(posedge clk) begin
    if (!time_reset_n) btn_q <= '0;
    else               btn_q <= btn_now;
  end

  // FSM state register; reset always lands in RUN.
  always_ff @(posedge clk) begin
    if (!time_reset_n) state_q <= ST_RUN;
    else               state_q <= state_nxt;
  end

  // FSM next state and running flag: each pause press toggles RUN/PAUSE.
  always_comb begin
    state_nxt = state_q;
    running   = (state_q == ST_RUN);
    if (pause_edge) state_nxt = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
  end

  // One-second advance with sec->min->hour carries; 23:59:59 wraps to midnight in one step.
  always_comb begin
    tick_time = time_q;
    if (time_q.sec == MAX_MINSEC) begin
      tick_time.sec = 6'd0;
      if (time_q.min == MAX_MINSEC) begin
        tick_time.min  = 6'd0;
        tick_time.hour = (time_q.hour == MAX_HOUR) ? 5'd0 : time_q.hour + 5'd1;
      end else begin
        tick_time.min = time_q.min + 6'd1;
      end
    end else begin
      tick_time.sec = time_q.sec + 6'd1;
    end
  end

  // Button edits with wrap-around; opposing edges on the same field cancel out, seconds untouched.
  always_comb begin
    edit_time = time_q;
    if (hr_inc_edge && !hr_dec_edge)
      edit_time.hour = (time_q.hour == MAX_HOUR) ? 5'd0 : time_q.hour + 5'd1;
    else if (hr_dec_edge && !hr_inc_edge)
      edit_time.hour = (time_q.hour == 5'd0) ? MAX_HOUR : time_q.hour - 5'd1;
    if (mn_inc_edge && !mn_dec_edge)
      edit_time.min = (time_q.min == MAX_MINSEC) ? 6'd0 : time_q.min + 6'd1;
    else if (mn_dec_edge && !mn_inc_edge)
      edit_time.min = (time_q.min == 6'd0) ? MAX_MINSEC : time_q.min - 6'd1;
  end

  // Only a real tick advance in RUN may trigger an alarm, never a load or an edit.
  assign tick_adv = (state_q == ST_RUN) && bus.tick && !bus.time_ow;

  // Next-time select: overwrite beats tick and buttons; an out-of-range load is dropped.
  always_comb begin
    time_nxt = time_q;
    if (bus.time_ow) begin
      if (time_valid(ow_time)) time_nxt = ow_time;
    end else if (state_q == ST_RUN) begin
      if (bus.tick) time_nxt = tick_time;
    end else begin
      time_nxt = edit_time;
    end
  end

  // Time register; reset loads initial_time, or midnight if it is out of range.
  always_ff @(posedge clk) begin
    if (!time_reset_n) begin
      if (time_valid(init_time)) time_q <= init_time;
      else                       time_q <= '0;
    end else begin
      time_q <= time_nxt;
    end
  end

  // Display hour mapping; the stored time stays in 24 h form either way.
  always_comb begin
    disp_hour = time_q.hour;
    pm_flag   = 1'b0;
    if (HOUR_12 != 0) begin
      if (time_q.hour == 5'd0) begin
        disp_hour = 5'd12;
      end else if (time_q.hour > 5'd12) begin
        disp_hour = time_q.hour - 5'd12;
        pm_flag   = 1'b1;
      end else if (time_q.hour == 5'd12) begin
        pm_flag = 1'b1;
      end
    end
  end

  bin2bcd_2dig u_bcd_hour (.bin({1'b0, disp_hour}), .tens(bcd_hour[7:4]), .ones(bcd_hour[3:0]));
  bin2bcd_2dig u_bcd_min  (.bin(time_q.min),        .tens(bcd_min[7:4]),  .ones(bcd_min[3:0]));
  bin2bcd_2dig u_bcd_sec  (.bin(time_q.sec),        .tens(bcd_sec[7:4]),  .ones(bcd_sec[3:0]));

  assign bus.hour_out = disp_hour;
  assign bus.min_out  = time_q.min;
  assign bus.sec_out  = time_q.sec;
  assign bus.pm       = pm_flag;
  assign bus.running  = running;
  assign bus.bcd_out  = {bcd_hour, bcd_min, bcd_sec};

`ifdef ALARM_TIMEKEEPER_ALARM_EN
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [NUM_ALARMS-1:0] ring_q, ring_hit;
  logic                  wr_ok;

  assign wr_ok = (bus.time_in[16:12] <= MAX_HOUR) && (bus.time_in[11:6] <= MAX_MINSEC);

  // Selects beyond the last channel match no channel and are thereby ignored.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    logic        sel_hit;
    logic        en_q;
    logic [10:0] hm_q;

    assign sel_hit = (bus.alarm_sel == SEL_W'(i));

    // Alarm programming; a clear on this channel overrides a same-cycle write.
    always_ff @(posedge clk) begin
      if (!time_reset_n) begin
        en_q <= 1'b0;
      end else if (sel_hit && bus.alarm_clr) begin
        en_q <= 1'b0;
      end else if (sel_hit && bus.alarm_wr && wr_ok) begin
        en_q <= 1'b1;
        hm_q <= bus.time_in[16:6];
      end
    end

    assign ring_hit[i] = en_q && tick_adv && (tick_time.sec == 6'd0) &&
                         ({tick_time.hour, tick_time.min} == hm_q);
  end

  // Latched ring flags; acknowledge beats a same-cycle hit.
  always_ff @(posedge clk) begin
    if (!time_reset_n)     ring_q <= '0;
    else if (bus.alarm_ack) ring_q <= '0;
    else                   ring_q <= ring_q | ring_hit;
  end

  assign bus.alarm_ring = ring_q;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{bus.alarm_wr, bus.alarm_clr, bus.alarm_sel, bus.alarm_ack, tick_adv};
  assign bus.alarm_ring = '0;
`endif

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench: two alarm_timekeeper instances (24 h and 12 h display) fed identical stimulus.
// Reference model keeps time as seconds-of-day; expected outputs are queued per clk and popped by a monitor.
// Alarm expectations follow ALARM_TIMEKEEPER_ALARM_EN.
module tb_alarm_timekeeper;

`ifdef ALARM_TIMEKEEPER_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        tick, time_ow, time_pause, hour_inc, hour_dec, min_inc, min_dec;
  logic        alarm_wr, alarm_clr, alarm_ack;
  logic [0:0]  alarm_sel;
  logic [16:0] time_in, initial_time;

  int total = 0;
  int bad   = 0;

  alarm_timekeeper_if #(.NUM_ALARMS(2)) ifc24 ();
  alarm_timekeeper_if #(.NUM_ALARMS(2)) ifc12 ();

  assign ifc24.tick = tick;          assign ifc12.tick = tick;
  assign ifc24.time_ow = time_ow;    assign ifc12.time_ow = time_ow;
  assign ifc24.time_in = time_in;    assign ifc12.time_in = time_in;
  assign ifc24.initial_time = initial_time; assign ifc12.initial_time = initial_time;
  assign ifc24.time_pause = time_pause;     assign ifc12.time_pause = time_pause;
  assign ifc24.hour_inc = hour_inc;  assign ifc12.hour_inc = hour_inc;
  assign ifc24.hour_dec = hour_dec;  assign ifc12.hour_dec = hour_dec;
  assign ifc24.min_inc = min_inc;    assign ifc12.min_inc = min_inc;
  assign ifc24.min_dec = min_dec;    assign ifc12.min_dec = min_dec;
  assign ifc24.alarm_wr = alarm_wr;  assign ifc12.alarm_wr = alarm_wr;
  assign ifc24.alarm_clr = alarm_clr; assign ifc12.alarm_clr = alarm_clr;
  assign ifc24.alarm_sel = alarm_sel; assign ifc12.alarm_sel = alarm_sel;
  assign ifc24.alarm_ack = alarm_ack; assign ifc12.alarm_ack = alarm_ack;

  alarm_timekeeper #(.HOUR_12(0), .NUM_ALARMS(2)) dut24 (.clk(clk), .time_reset_n(rst_n), .bus(ifc24));
  alarm_timekeeper #(.HOUR_12(1), .NUM_ALARMS(2)) dut12 (.clk(clk), .time_reset_n(rst_n), .bus(ifc12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_t;        // seconds since midnight
  bit       m_run;
  bit [4:0] m_prev;
  bit [1:0] m_en, m_ring;
  int       m_alm [2];  // alarm minute-of-day

  function automatic bit fld_ok(input logic [16:0] v, input bit with_sec);
    return (v[16:12] <= 23) && (v[11:6] <= 59) && (!with_sec || v[5:0] <= 59);
  endfunction

  function automatic int to_secs(input logic [16:0] v);
    return int'(v[16:12]) * 3600 + int'(v[11:6]) * 60 + int'(v[5:0]);
  endfunction

  task automatic model_step();
    bit [4:0] cur, e;
    bit [1:0] hit;
    int h, m, s, dh, dm, sel;
    if (!rst_n) begin
      m_t = fld_ok(initial_time, 1'b1) ? to_secs(initial_time) : 0;
      m_run = 1'b1; m_prev = '0; m_en = '0; m_ring = '0;
      return;
    end
    cur = {time_pause, hour_inc, hour_dec, min_inc, min_dec};
    e   = cur & ~m_prev;
    hit = '0;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    if (time_ow) begin
      if (fld_ok(time_in, 1'b1)) m_t = to_secs(time_in);
    end else if (m_run) begin
      if (tick) begin
        m_t = (m_t + 1) % 86400;
        for (int i = 0; i < 2; i++)
          if (m_en[i] && m_t == m_alm[i] * 60) hit[i] = 1'b1;
      end
    end else begin
      dh = int'(e[3]) - int'(e[2]);
      dm = int'(e[1]) - int'(e[0]);
      m_t = ((h + dh + 24) % 24) * 3600 + ((m + dm + 60) % 60) * 60 + s;
    end
    m_ring = alarm_ack ? 2'b00 : (m_ring | hit);
    sel = int'(alarm_sel);
    if (alarm_clr) m_en[sel] = 1'b0;
    else if (alarm_wr && fld_ok(time_in, 1'b0)) begin
      m_en[sel]  = 1'b1;
      m_alm[sel] = int'(time_in[16:12]) * 60 + int'(time_in[11:6]);
    end
    if (e[4]) m_run = !m_run;
    m_prev = cur;
  endtask

  function automatic logic [63:0] exp_vec(input bit h12);
    int h, mi, s, dh;
    bit p;
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    if (!h12) begin
      dh = h; p = 1'b0;
    end else begin
      p  = (h >= 12);
      dh = h % 12;
      if (dh == 0) dh = 12;
    end
    return {17'd0, 5'(dh), 6'(mi), 6'(s), p, m_run,
            4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            2'b00, (ALARM_ON ? m_ring : 2'b00)};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [63:0] e24;
    logic [63:0] e12;
  } exp_t;
  exp_t exp_q[$];

  logic [46:0] act24, act12;
  assign act24 = {ifc24.hour_out, ifc24.min_out, ifc24.sec_out, ifc24.pm, ifc24.running,
                  ifc24.bcd_out, 2'b00, ifc24.alarm_ring};
  assign act12 = {ifc12.hour_out, ifc12.min_out, ifc12.sec_out, ifc12.pm, ifc12.running,
                  ifc12.bcd_out, 2'b00, ifc12.alarm_ring};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.name, "_24h"}, {17'd0, act24}, e.e24);
      check({e.name, "_12h"}, {17'd0, act12}, e.e12);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input string nm);
    exp_t e;
    @(posedge clk);
    model_step();
    e.name = nm;
    e.e24  = exp_vec(1'b0);
    e.e12  = exp_vec(1'b1);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; tick = 1'b0; time_ow = 1'b0; time_pause = 1'b0;
    hour_inc = 1'b0; hour_dec = 1'b0; min_inc = 1'b0; min_dec = 1'b0;
    alarm_wr = 1'b0; alarm_clr = 1'b0; alarm_ack = 1'b0; alarm_sel = 1'b0;
  endtask

  task automatic load_time(input int hh, input int mm, input int ss, input string nm);
    time_ow = 1'b1;
    time_in = {5'(hh), 6'(mm), 6'(ss)};
    step(nm);
    time_ow = 1'b0;
  endtask

  task automatic write_alarm(input int ch, input int hh, input int mm, input bit clr);
    alarm_wr = 1'b1; alarm_clr = clr; alarm_sel = 1'(ch);
    time_in = {5'(hh), 6'(mm), 6'd0};
    step(clr ? "alarm_wr_clr" : "alarm_wr");
    alarm_wr = 1'b0; alarm_clr = 1'b0;
  endtask

  function automatic logic [16:0] rand_time();
    return {5'($urandom_range(0, 24)), 6'($urandom_range(0, 60)), 6'($urandom_range(0, 60))};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int am;
    idle();
    time_in = '0;

    // reset from 12:34:56, then four ticks
    initial_time = {5'd12, 6'd34, 6'd56};
    rst_n = 1'b0;
    step("reset"); step("reset");
    rst_n = 1'b1;
    tick = 1'b1;
    repeat (4) step("tick4");
    tick = 1'b0;
    drain();
    check("bcd_123500", 64'(ifc24.bcd_out), 64'(24'h123500));

    // midnight rollover, with an alarm parked one minute later
    write_alarm(0, 0, 1, 1'b0);
    load_time(23, 59, 59, "ow_235959");
    tick = 1'b1; step("rollover"); tick = 1'b0;
    step("after_roll");
    drain();
    check("midnight_hms", 64'({ifc24.hour_out, ifc24.min_out, ifc24.sec_out}), 64'(17'd0));
    check("midnight_ring", 64'(ifc24.alarm_ring), 64'(2'b00));

    // 12 h display corners
    load_time(0, 15, 0, "ow_0015");
    drain();
    check("h12_0015", 64'({ifc12.hour_out, ifc12.pm}), 64'({5'd12, 1'b0}));
    load_time(13, 0, 0, "ow_1300");
    drain();
    check("h12_1300", 64'({ifc12.hour_out, ifc12.pm}), 64'({5'd1, 1'b1}));
    check("h24_1300", 64'({ifc24.hour_out, ifc24.pm}), 64'({5'd13, 1'b0}));

    // pause, held min_inc with ticks ignored, hour_dec wraps from 0
    load_time(0, 10, 20, "ow_001020");
    time_pause = 1'b1; step("pause_edge");
    time_pause = 1'b0; step("paused");
    min_inc = 1'b1; tick = 1'b1;
    repeat (10) step("min_inc_held");
    min_inc = 1'b0; tick = 1'b0; step("min_rel");
    hour_dec = 1'b1; step("hour_dec");
    hour_dec = 1'b0; step("hour_rel");
    drain();
    check("edit_result", 64'({ifc24.hour_out, ifc24.min_out, ifc24.sec_out, ifc24.running}),
          64'({5'd23, 6'd11, 6'd20, 1'b0}));
    hour_inc = 1'b1; hour_dec = 1'b1; min_dec = 1'b1; step("inc_dec_same");
    hour_inc = 1'b0; hour_dec = 1'b0; min_dec = 1'b0; step("rel");
    time_pause = 1'b1; step("resume_edge");
    time_pause = 1'b0; step("resumed");

    // alarm 1 at 07:30 from 07:29:58
    write_alarm(1, 7, 30, 1'b0);
    load_time(7, 29, 58, "ow_072958");
    tick = 1'b1; repeat (2) step("tick_to_alarm"); tick = 1'b0;
    repeat (3) step("ring_hold");
    drain();
    check("ring_set", 64'(ifc24.alarm_ring), 64'(ALARM_ON ? 2'b10 : 2'b00));
    alarm_ack = 1'b1; step("ack"); alarm_ack = 1'b0;
    drain();
    check("ring_acked", 64'(ifc24.alarm_ring), 64'(2'b00));

    // invalid load ignored; wr+clr leaves channel 0 off while channel 1 fires
    load_time(10, 20, 30, "ow_102030");
    load_time(10, 60, 0, "ow_bad_min");
    drain();
    check("bad_load", 64'({ifc24.hour_out, ifc24.min_out, ifc24.sec_out}),
          64'({5'd10, 6'd20, 6'd30}));
    write_alarm(1, 10, 21, 1'b0);
    write_alarm(0, 10, 21, 1'b1);
    tick = 1'b1; repeat (30) step("tick_to_1021"); tick = 1'b0;
    step("ring_hold2");
    drain();
    check("wr_clr_ring", 64'(ifc24.alarm_ring), 64'(ALARM_ON ? 2'b10 : 2'b00));

    // reset while ringing, invalid initial_time falls back to midnight
    initial_time = {5'd24, 6'd0, 6'd0};
    rst_n = 1'b0; step("reset_mid_ring");
    rst_n = 1'b1; step("post_reset");
    drain();
    check("reset_abort", 64'({ifc24.hour_out, ifc24.min_out, ifc24.sec_out, ifc24.running, ifc24.alarm_ring}),
          64'({17'd0, 1'b1, 2'b00}));

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 999) != 0);
      initial_time = rand_time();
      tick         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) time_pause = ~time_pause;
      if ($urandom_range(0, 3) == 0) hour_inc = ~hour_inc;
      if ($urandom_range(0, 3) == 0) hour_dec = ~hour_dec;
      if ($urandom_range(0, 3) == 0) min_inc = ~min_inc;
      if ($urandom_range(0, 3) == 0) min_dec = ~min_dec;
      time_ow   = ($urandom_range(0, 59) == 0);
      alarm_wr  = ($urandom_range(0, 39) == 0);
      alarm_clr = ($urandom_range(0, 79) == 0);
      alarm_ack = ($urandom_range(0, 29) == 0);
      alarm_sel = 1'($urandom_range(0, 1));
      if (alarm_wr) begin
        am = (m_t / 60 + int'($urandom_range(1, 2))) % 1440;
        time_in = {5'(am / 60), 6'(am % 60), 6'($urandom_range(0, 59))};
      end else begin
        time_in = rand_time();
      end
      step("random");
    end
    idle();
    step("final");
    drain();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
